register_file_sb: RTL and testbench
===================================

Name: register_file_sb

Overview:
- Parametrised multi-port register file for the pipelined CPU datapath.
- Generalises the single-write, two-read file in data width, register count, read-port count and write-port count.
- Adds optional same-cycle write-to-read bypass.
- Adds a per-register busy scoreboard: issue sets busy; writeback or flush clears it. Decode uses it for hazard stalls.

Parameters:
- DATA_W, 32, register width in bits.
- NREGS, 32, number of architectural registers; power of 2, at least 2.
- NRD, 2, number of read ports.
- NWR, 2, number of write ports; a higher index has priority.
- BYPASS, 1, 1 means reads see same-cycle writes and same-cycle busy clears.
- ZERO_REG, 1, 1 means register 0 is hardwired to zero and never busy.
- Derived: AW = $clog2(NREGS).

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- wen  in  NWR  per-port write enable.
- wsel  in  NWR x AW  per-port write address.
- wdat  in  NWR x DATA_W  per-port write data.
- rsel  in  NRD x AW  per-port read address.
- rdat  out  NRD x DATA_W  per-port read data, combinational.
- rbusy  out  NRD  busy flag of the register at rsel, combinational.
- busy_set  in  1  issue: mark busy_sel pending.
- busy_sel  in  AW  destination register being issued.
- flush  in  1  clear all busy bits (pipeline squash).
- busy_vec  out  NREGS  raw scoreboard state, for debug and the hazard unit.

Behaviour:
- Reset (nRST low, asynchronous): all registers 0, all busy bits 0. Hence rdat = 0, rbusy = 0, busy_vec = 0 while reset is held. Reset mid-operation discards all pending writes and sets.
- Writes: on the rising CLK edge, each port p with wen[p]=1 writes wdat[p] into Reg[wsel[p]].
  - If several ports target the same wsel, the highest-index port wins.
  - With ZERO_REG=1, writes to register 0 are ignored.
- Reads: zero latency.
  - rdat[r] = 0 if ZERO_REG and rsel[r]=0.
  - Else, if BYPASS and some enabled port writes rsel[r] this cycle, rdat[r] = wdat of the highest such port.
  - Else rdat[r] = Reg[rsel[r]].
  - With BYPASS=0, a written value appears on rdat the cycle after the edge.
- Scoreboard: next-state per register i, evaluated in priority order.
  1. flush=1: busy[i] <= 0 for all i. Flush beats a same-cycle busy_set.
  2. busy_set=1 and busy_sel=i: busy[i] <= 1. Set beats a same-cycle writeback clear, because the new issue supersedes the old result.
  3. Any enabled write port with wsel=i: busy[i] <= 0.
  4. Otherwise hold.
  - With ZERO_REG=1, busy[0] is constantly 0 and busy_set to register 0 is ignored.
- rbusy[r]:
  - BYPASS=1: busy[rsel[r]] AND NOT (a write to rsel[r] this cycle). A writeback releases the hazard in the same cycle.
  - BYPASS=0: busy[rsel[r]] raw.
  - Forced to 0 for register 0 when ZERO_REG=1.
- rbusy does not include a same-cycle busy_set; decode handles its own-cycle hazard.
- A write to a non-busy register is legal and clears nothing extra.
- Width rules:
  - Addresses are unsigned AW bits; no out-of-range addresses exist.
  - Data is stored unmodified; no sign or zero extension.

Decomposition:
- cpu_types_pkg: word_t (DATA_W=32 default), regbits_t (AW-bit), and constants NREGS_DEF=32, NRD_DEF=2, NWR_DEF=2.
- Sub-module rf_scoreboard holds the busy vector, the set/clear/flush priority and the rbusy generation.
- The parent holds the data array, the write-port priority mux and the bypass mux.

Test Plan:
- Reset held, then released with no activity -> every rdat = 0, rbusy = 0, busy_vec = 0.
- wen = 2'b11, wsel = {5, 5}, wdat = {0xBBBB0000 on port1, 0xAAAA0000 on port0}, rsel0 = 5, BYPASS=1 -> rdat0 = 0xBBBB0000 in the same cycle and after the edge. With BYPASS=0, rdat0 = old value that cycle, then 0xBBBB0000.
- Write 0xDEADBEEF to register 0 with ZERO_REG=1 -> rdat = 0; busy_set on register 0 -> busy_vec[0] stays 0.
- busy_set, busy_sel = 7; next cycle rsel1 = 7 -> rbusy1 = 1. Then write port0 to register 7 -> rbusy1 = 0 that same cycle (BYPASS=1) and busy_vec[7] = 0 after the edge.
- Same cycle: busy_set on register 9 and a write to register 9 -> busy_vec[9] = 1 after the edge. Add flush in that cycle -> busy_vec = 0.
- Register 3 busy, then nRST pulsed low mid-cycle (asynchronous) -> busy_vec = 0 and rdat for register 3 = 0 immediately, without a clock edge.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared datapath types and default register-file geometry
package cpu_types_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF = 2;
  localparam int NWR_DEF = 2;
  localparam int AW_DEF = $clog2(NREGS_DEF);
  typedef logic [DATA_W_DEF-1:0] word_t;
  typedef logic [AW_DEF-1:0] regbits_t;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits with flush > issue > writeback priority
module rf_scoreboard
  import cpu_types_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NRD = NRD_DEF,
  parameter int NWR = NWR_DEF,
  parameter int BYPASS = 1,
  parameter int ZERO_REG = 1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [NWR-1:0]           wen,
  input  logic [NWR-1:0][AW-1:0]   wsel,
  input  logic [NRD-1:0][AW-1:0]   rsel,
  input  logic                     busy_set,
  input  logic [AW-1:0]            busy_sel,
  input  logic                     flush,
  output logic [NRD-1:0]           rbusy,
  output logic [NREGS-1:0]         busy_vec
);
  logic [NREGS-1:0] busy, busy_next, clr, set;
  // decode writeback clears and issue set, then apply priority
  always_comb begin
    clr = '0;
    set = '0;
    for (int p = 0; p < NWR; p++)
      if (wen[p]) clr[wsel[p]] = 1'b1;
    if (busy_set) set[busy_sel] = 1'b1;
    busy_next = flush ? '0 : (busy & ~clr) | set;
    if (ZERO_REG != 0) busy_next[0] = 1'b0;
  end
  // scoreboard state
  always_ff @(posedge CLK, negedge nRST)
    if (!nRST) busy <= '0;
    else busy <= busy_next;
  // a same-cycle writeback releases the hazard only when bypassing
  always_comb begin
    rbusy = '0;
    for (int r = 0; r < NRD; r++)
      rbusy[r] = busy[rsel[r]] & ~((BYPASS != 0) & clr[rsel[r]])
               & ~((ZERO_REG != 0) & (rsel[r] == '0));
  end
  assign busy_vec = busy;
endmodule

// File: rtl/register_file_sb.sv
// register_file_sb: multi-port register file with write bypass and busy scoreboard
module register_file_sb
  import cpu_types_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD = NRD_DEF,
  parameter int NWR = NWR_DEF,
  parameter int BYPASS = 1,
  parameter int ZERO_REG = 1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic [NWR-1:0]             wen,
  input  logic [NWR-1:0][AW-1:0]     wsel,
  input  logic [NWR-1:0][DATA_W-1:0] wdat,
  input  logic [NRD-1:0][AW-1:0]     rsel,
  output logic [NRD-1:0][DATA_W-1:0] rdat,
  output logic [NRD-1:0]             rbusy,
  input  logic                       busy_set,
  input  logic [AW-1:0]              busy_sel,
  input  logic                       flush,
  output logic [NREGS-1:0]           busy_vec
);
  logic [NREGS-1:0][DATA_W-1:0] regs;
  // later ports are applied last so the highest-index port wins
  always_ff @(posedge CLK, negedge nRST)
    if (!nRST) regs <= '0;
    else
      for (int p = 0; p < NWR; p++)
        if (wen[p] && !((ZERO_REG != 0) && (wsel[p] == '0))) regs[wsel[p]] <= wdat[p];
  // read mux: stored value, overridden by same-cycle writes, then zero register
  always_comb begin
    rdat = '0;
    for (int r = 0; r < NRD; r++) begin
      rdat[r] = regs[rsel[r]];
      if (BYPASS != 0)
        for (int p = 0; p < NWR; p++)
          if (wen[p] && (wsel[p] == rsel[r])) rdat[r] = wdat[p];
      if ((ZERO_REG != 0) && (rsel[r] == '0)) rdat[r] = '0;
    end
  end
  rf_scoreboard #(
    .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
  ) u_sb (
    .CLK(CLK), .nRST(nRST), .wen(wen), .wsel(wsel), .rsel(rsel),
    .busy_set(busy_set), .busy_sel(busy_sel), .flush(flush),
    .rbusy(rbusy), .busy_vec(busy_vec)
  );
endmodule

// File: tb/tb_register_file_sb.sv
// tb_register_file_sb: directed checks of the bypassing and non-bypassing register file
module tb_register_file_sb;
  import cpu_types_pkg::*;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic [1:0] wen = '0;
  regbits_t [1:0] wsel = '0;
  word_t [1:0] wdat = '0;
  regbits_t [1:0] rsel = '0;
  logic busy_set = 1'b0;
  regbits_t busy_sel = '0;
  logic flush = 1'b0;
  word_t [1:0] rdat, rdat_nb;
  logic [1:0] rbusy, rbusy_nb;
  logic [31:0] busy_vec, busy_vec_nb;
  int n_vec = 0;
  int n_err = 0;

  register_file_sb #(.BYPASS(1)) u_dut (
    .CLK(CLK), .nRST(nRST), .wen(wen), .wsel(wsel), .wdat(wdat), .rsel(rsel),
    .rdat(rdat), .rbusy(rbusy), .busy_set(busy_set), .busy_sel(busy_sel),
    .flush(flush), .busy_vec(busy_vec)
  );
  register_file_sb #(.BYPASS(0)) u_nb (
    .CLK(CLK), .nRST(nRST), .wen(wen), .wsel(wsel), .wdat(wdat), .rsel(rsel),
    .rdat(rdat_nb), .rbusy(rbusy_nb), .busy_set(busy_set), .busy_sel(busy_sel),
    .flush(flush), .busy_vec(busy_vec_nb)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wen = '0;
    wsel = '0;
    wdat = '0;
    busy_set = 1'b0;
    busy_sel = '0;
    flush = 1'b0;
  endtask

  task automatic edge_settle();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    check("rst_rdat0", rdat[0], 0);
    check("rst_busy_vec", busy_vec, 0);
    @(negedge CLK);
    nRST = 1'b1;
    edge_settle();
    check("idle_rdat0", rdat[0], 0);
    check("idle_rdat1", rdat[1], 0);
    check("idle_rbusy", rbusy, 0);
    check("idle_busy_vec", busy_vec, 0);

    @(negedge CLK);
    wen = 2'b11; wsel[1] = 5; wsel[0] = 5;
    wdat[1] = 32'hBBBB0000; wdat[0] = 32'hAAAA0000; rsel[0] = 5;
    #1;
    check("byp_same_cycle", rdat[0], 32'hBBBB0000);
    check("nb_same_cycle_old", rdat_nb[0], 0);
    edge_settle();
    check("nb_after_edge", rdat_nb[0], 32'hBBBB0000);
    @(negedge CLK);
    idle();
    #1;
    check("byp_stored_hi_port", rdat[0], 32'hBBBB0000);

    @(negedge CLK);
    wen = 2'b11; wsel[0] = 6; wdat[0] = 32'h0000_0066; wsel[1] = 8; wdat[1] = 32'h8000_0008;
    rsel[0] = 6; rsel[1] = 8;
    edge_settle();
    @(negedge CLK);
    idle();
    #1;
    check("port0_stored", rdat_nb[0], 32'h0000_0066);
    check("port1_stored", rdat_nb[1], 32'h8000_0008);

    @(negedge CLK);
    wen = 2'b01; wsel[0] = 0; wdat[0] = 32'hDEADBEEF; rsel[0] = 0;
    busy_set = 1'b1; busy_sel = 0;
    #1;
    check("zero_byp", rdat[0], 0);
    edge_settle();
    check("zero_busy_vec", busy_vec, 0);
    @(negedge CLK);
    idle();
    #1;
    check("zero_stored", rdat_nb[0], 0);

    @(negedge CLK);
    busy_set = 1'b1; busy_sel = 7;
    edge_settle();
    check("set7_busy_vec", busy_vec, 32'h0000_0080);
    @(negedge CLK);
    idle();
    rsel[1] = 7;
    #1;
    check("set7_rbusy1", rbusy[1], 1);
    @(negedge CLK);
    wen = 2'b01; wsel[0] = 7; wdat[0] = 32'h0000_0077;
    #1;
    check("wb7_rbusy1_byp", rbusy[1], 0);
    check("wb7_rbusy1_nb", rbusy_nb[1], 1);
    check("wb7_rdat1_byp", rdat[1], 32'h0000_0077);
    edge_settle();
    check("wb7_busy_vec", busy_vec, 0);
    check("wb7_busy_vec_nb", busy_vec_nb, 0);

    @(negedge CLK);
    idle();
    busy_set = 1'b1; busy_sel = 9; wen = 2'b10; wsel[1] = 9; wdat[1] = 32'h0000_0099;
    edge_settle();
    check("set_beats_clr", busy_vec, 32'h0000_0200);
    @(negedge CLK);
    flush = 1'b1;
    edge_settle();
    check("flush_beats_set", busy_vec, 0);

    @(negedge CLK);
    idle();
    wen = 2'b01; wsel[0] = 3; wdat[0] = 32'h3333_3333;
    @(negedge CLK);
    idle();
    busy_set = 1'b1; busy_sel = 3; rsel[0] = 3;
    edge_settle();
    @(negedge CLK);
    idle();
    #1;
    check("pre_rst_busy_vec", busy_vec, 32'h0000_0008);
    check("pre_rst_rdat0", rdat[0], 32'h3333_3333);
    check("pre_rst_rbusy0", rbusy[0], 1);
    @(posedge CLK);
    #2;
    nRST = 1'b0;
    #1;
    check("async_rst_busy_vec", busy_vec, 0);
    check("async_rst_rdat0", rdat[0], 0);
    check("async_rst_rdat0_nb", rdat_nb[0], 0);
    @(negedge CLK);
    nRST = 1'b1;
    edge_settle();
    check("post_rst_rdat0", rdat[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
